// File: rtl/wb_stream_master_pkg.sv
// Shared Wishbone definitions: burst-engine FSM state encoding.
package wb_stream_master_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrData,
      StWrBus,
      StRdBus,
      StRdOut,
      StDone
   } wb_state_e;

endpackage

// File: rtl/wb_stream_master.sv
// Wishbone burst master: moves cmd_len words between the streams and the bus, one
// single-beat strobe per word, with sticky error flag and one-cycle done pulse.
module wb_stream_master
   import wb_stream_master_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned SELECT_WIDTH = 4,
   parameter int unsigned LEN_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [LEN_WIDTH-1:0]    cmd_len,
   input  logic                    cmd_we,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [DATA_WIDTH-1:0]   s_wr_data,
   input  logic                    s_wr_valid,
   output logic                    s_wr_ready,
   output logic [DATA_WIDTH-1:0]   m_rd_data,
   output logic                    m_rd_valid,
   input  logic                    m_rd_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [ADDR_WIDTH-1:0]   m_adr_o,
   input  logic [DATA_WIDTH-1:0]   m_dat_i,
   output logic [DATA_WIDTH-1:0]   m_dat_o,
   output logic                    m_we_o,
   output logic [SELECT_WIDTH-1:0] m_sel_o,
   output logic                    m_stb_o,
   input  logic                    m_ack_i,
   input  logic                    m_err_i,
   output logic                    m_cyc_o
);

   localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(SELECT_WIDTH);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

   wb_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
   logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
   logic                  err_q, err_d;
   logic                  cyc_q, cyc_d;
   logic                  bus_ack, bus_err;

   // Error wins over a simultaneous ack; responses without a strobe are ignored.
   assign bus_err = m_stb_o & m_err_i;
   assign bus_ack = m_stb_o & m_ack_i & ~m_err_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         adr_q   <= '0;
         len_q   <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         err_q   <= 1'b0;
         cyc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         len_q   <= len_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         err_q   <= err_d;
         cyc_q   <= cyc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      len_d   = len_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      err_d   = err_q;
      cyc_d   = cyc_q;
      unique case (state_q)
         StIdle: begin
            cyc_d = 1'b0;
            if (cmd_valid) begin
               adr_d = cmd_addr;
               len_d = cmd_len;
               err_d = 1'b0;
               if (cmd_len == '0) begin
                  state_d = StDone;
               end else if (cmd_we) begin
                  state_d = StWrData;
               end else begin
                  state_d = StRdBus;
               end
            end
         end
         StWrData: begin
            if (s_wr_valid) begin
               wdat_d  = s_wr_data;
               state_d = StWrBus;
            end
         end
         StWrBus: begin
            // Keeps the cycle open across stream stalls once the first strobe went out.
            cyc_d = 1'b1;
            if (bus_err) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else if (bus_ack) begin
               adr_d   = adr_q + ADR_STEP;
               len_d   = len_q - LEN_ONE;
               state_d = (len_q == LEN_ONE) ? StDone : StWrData;
            end
         end
         StRdBus: begin
            cyc_d = 1'b1;
            if (bus_err) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else if (bus_ack) begin
               rdat_d  = m_dat_i;
               adr_d   = adr_q + ADR_STEP;
               len_d   = len_q - LEN_ONE;
               state_d = StRdOut;
            end
         end
         StRdOut: begin
            if (m_rd_ready) begin
               state_d = (len_q == '0) ? StDone : StRdBus;
            end
         end
         StDone: begin
            cyc_d   = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd_ready  = 1'b0;
      s_wr_ready = 1'b0;
      m_rd_valid = 1'b0;
      m_stb_o    = 1'b0;
      m_we_o     = 1'b0;
      done       = 1'b0;
      m_cyc_o    = cyc_q;
      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            m_cyc_o   = 1'b0;
         end
         StWrData: s_wr_ready = 1'b1;
         StWrBus: begin
            m_stb_o = 1'b1;
            m_we_o  = 1'b1;
            m_cyc_o = 1'b1;
         end
         StRdBus: begin
            m_stb_o = 1'b1;
            m_cyc_o = 1'b1;
         end
         StRdOut: m_rd_valid = 1'b1;
         StDone: begin
            done    = 1'b1;
            m_cyc_o = 1'b0;
         end
         default: m_cyc_o = 1'b0;
      endcase
   end

   assign busy      = (state_q != StIdle);
   assign err       = err_q;
   assign m_adr_o   = adr_q;
   assign m_dat_o   = wdat_q;
   assign m_rd_data = rdat_q;
   assign m_sel_o   = '1;

endmodule

// File: tb/tb_wb_stream_master.sv
// Bench for wb_stream_master: RAM slave with random latency, spurious responses and
// error injection; expectations come from a word-array model of memory contents.
module tb_wb_stream_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cmd_addr = '0;
   logic [15:0] cmd_len = '0;
   logic        cmd_we = 1'b0, cmd_valid = 1'b0, cmd_ready;
   logic [31:0] s_wr_data = '0;
   logic        s_wr_valid = 1'b0, s_wr_ready;
   logic [31:0] m_rd_data;
   logic        m_rd_valid, m_rd_ready = 1'b0;
   logic        busy, done, err;
   logic [31:0] m_adr_o, m_dat_i, m_dat_o;
   logic        m_we_o, m_stb_o, m_ack_i, m_err_i, m_cyc_o;
   logic [3:0]  m_sel_o;

   // Narrow-address instance for the wrap case.
   logic [7:0]  cmd_addr8 = '0;
   logic [15:0] cmd_len8 = '0;
   logic        cmd_valid8 = 1'b0, cmd_ready8;
   logic        s_wr_ready8, m_rd_valid8, busy8, done8, err8;
   logic [31:0] m_rd_data8, m_dat_o8;
   logic [7:0]  m_adr8;
   logic        m_we8, m_stb8, m_cyc8;
   logic [3:0]  m_sel8;
   logic        ack8_q = 1'b0;

   always #5 clk = ~clk;

   wb_stream_master u_dut (
      .clk(clk), .rst(rst),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_we(cmd_we),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .s_wr_data(s_wr_data), .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready),
      .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready),
      .busy(busy), .done(done), .err(err),
      .m_adr_o(m_adr_o), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_we_o(m_we_o),
      .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
      .m_cyc_o(m_cyc_o)
   );

   wb_stream_master #(.ADDR_WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .cmd_addr(cmd_addr8), .cmd_len(cmd_len8), .cmd_we(1'b0),
      .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
      .s_wr_data(32'h0), .s_wr_valid(1'b0), .s_wr_ready(s_wr_ready8),
      .m_rd_data(m_rd_data8), .m_rd_valid(m_rd_valid8), .m_rd_ready(1'b1),
      .busy(busy8), .done(done8), .err(err8),
      .m_adr_o(m_adr8), .m_dat_i(32'h5A), .m_dat_o(m_dat_o8), .m_we_o(m_we8),
      .m_sel_o(m_sel8), .m_stb_o(m_stb8), .m_ack_i(ack8_q), .m_err_i(1'b0),
      .m_cyc_o(m_cyc8)
   );

   // RAM slave
   logic [31:0] mem [256];
   logic        ack_q = 1'b0, err_q = 1'b0, spur_a = 1'b0, spur_e = 1'b0;
   int          beat = 0;
   int          err_beat = -1;
   logic [7:0]  midx;
   assign midx    = m_adr_o[9:2];
   assign m_dat_i = mem[midx];
   assign m_ack_i = ack_q | (spur_a & ~m_stb_o);
   assign m_err_i = err_q | (spur_e & ~m_stb_o);

   always @(posedge clk) begin
      spur_a <= ($urandom_range(0, 4) == 0);
      spur_e <= ($urandom_range(0, 6) == 0);
      if (cmd_valid && cmd_ready) beat <= 0;
      if (m_stb_o && m_cyc_o && !ack_q && !err_q && ($urandom_range(0, 2) != 0)) begin
         if (beat == err_beat) begin
            err_q <= 1'b1;
            ack_q <= 1'($urandom_range(0, 1));
         end else begin
            ack_q <= 1'b1;
         end
         beat <= beat + 1;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end
      if (m_stb_o && m_we_o && ack_q && !err_q) mem[midx] <= m_dat_o;
   end

   // Bus monitor
   logic [31:0] adr_log [$];
   int          ack_cnt = 0, viol = 0, cyc_drop = 0, cyc_cycles = 0;
   logic        prev_term = 1'b0, in_burst = 1'b0;
   logic [7:0]  adr8_log [$];

   always @(posedge clk) begin
      if (m_stb_o && prev_term) viol++;
      prev_term <= m_stb_o && (m_ack_i || m_err_i);
      if (m_stb_o && m_ack_i && !m_err_i) begin
         adr_log.push_back(m_adr_o);
         ack_cnt++;
      end
      if (in_burst && !m_cyc_o && !done && !rst) cyc_drop++;
      if (m_cyc_o) cyc_cycles++;
      if (done || rst) in_burst <= 1'b0;
      else if (m_stb_o) in_burst <= 1'b1;
      ack8_q <= m_stb8 && !ack8_q;
      if (m_stb8 && ack8_q) adr8_log.push_back(m_adr8);
   end

   int          n_cmp = 0, n_bad = 0;
   logic [31:0] exp_mem [256];
   logic [31:0] wdata [16];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic run_cmd(input logic [31:0] addr, input int len, input bit we, input int eb,
                          input bit tog);
      logic [31:0] got [$];
      logic [31:0] exp_adr;
      int wi, dones, lat, n_ok, log0, viol0, drop0, cyc0, idx;
      bit erred;
      wi = 0; dones = 0; lat = -1;
      log0 = adr_log.size(); viol0 = viol; drop0 = cyc_drop; cyc0 = cyc_cycles;
      idx = int'(addr[9:2]);
      erred = (eb >= 0) && (eb < len);
      n_ok = erred ? eb : len;
      err_beat = eb;
      @(negedge clk);
      cmd_addr = addr; cmd_len = 16'(len); cmd_we = we; cmd_valid = 1'b1;
      check("cmd_ready", 64'(cmd_ready), 64'(1));
      @(negedge clk);
      cmd_valid = 1'b0;
      check("busy", 64'(busy), 64'(1));
      check("err_clear", 64'(err), 64'(0));
      for (int c = 0; c < 400; c++) begin
         if (done) begin
            dones = 1;
            lat = c;
            break;
         end
         s_wr_valid = we && (wi < len) && ($urandom_range(0, 3) != 0);
         s_wr_data  = wdata[wi % 16];
         m_rd_ready = tog ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (s_wr_valid && s_wr_ready) wi++;
         if (m_rd_valid && m_rd_ready) got.push_back(m_rd_data);
         @(negedge clk);
      end
      s_wr_valid = 1'b0;
      m_rd_ready = 1'b0;
      check("done_seen", 64'(dones), 64'(1));
      if (len == 0) check("zero_len_latency", 64'(lat), 64'(0));
      check("err_flag", 64'(err), 64'(erred));
      check("cyc_in_done", 64'(m_cyc_o), 64'(0));
      if (we) check("wr_consumed", 64'(wi), 64'(erred ? eb + 1 : len));
      else    check("rd_count", 64'(got.size()), 64'(n_ok));
      for (int i = 0; i < got.size() && i < n_ok; i++)
         check("rd_data", 64'(got[i]), 64'(exp_mem[idx + i]));
      check("ack_count", 64'(adr_log.size() - log0), 64'(n_ok));
      for (int i = 0; i < n_ok && log0 + i < adr_log.size(); i++) begin
         exp_adr = addr + 32'(4 * i);
         check("bus_adr", 64'(adr_log[log0 + i]), 64'(exp_adr));
      end
      check("stb_after_ack", 64'(viol - viol0), 64'(0));
      check("cyc_drop", 64'(cyc_drop - drop0), 64'(0));
      if (len == 0) check("no_cyc", 64'(cyc_cycles - cyc0), 64'(0));
      if (we) begin
         for (int i = 0; i < n_ok; i++) exp_mem[idx + i] = wdata[i];
         for (int i = 0; i < n_ok; i++)
            check("ram_word", 64'(mem[idx + i]), 64'(exp_mem[idx + i]));
      end
      @(negedge clk);
      check("done_width", 64'(done), 64'(0));
      check("idle_ready", 64'(cmd_ready), 64'(1));
      err_beat = -1;
   endtask

   initial begin
      int a0, c0, d8;
      logic [31:0] ra;
      int rl;

      repeat (3) @(negedge clk);
      check("rst_cyc", 64'(m_cyc_o), 64'(0));
      check("rst_stb", 64'(m_stb_o), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_adr", 64'(m_adr_o), 64'(0));
      check("rst_rdv", 64'(m_rd_valid), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(cmd_ready), 64'(1));

      for (int i = 0; i < 16; i++) wdata[i] = 32'hA0 + 32'(i);
      run_cmd(32'h100, 4, 1'b1, -1, 1'b0);
      run_cmd(32'h100, 4, 1'b0, -1, 1'b1);
      run_cmd(32'h200, 0, 1'b1, -1, 1'b0);
      run_cmd(32'h200, 0, 1'b0, -1, 1'b0);
      run_cmd(32'h100, 4, 1'b0, 1, 1'b1);
      run_cmd(32'h100, 1, 1'b0, -1, 1'b0);

      for (int k = 0; k < 6; k++) begin
         ra = 32'($urandom_range(0, 200)) << 2;
         rl = $urandom_range(1, 8);
         for (int i = 0; i < 16; i++) wdata[i] = $urandom;
         run_cmd(ra, rl, 1'b1, -1, 1'b0);
         run_cmd(ra, rl, 1'b0, -1, 1'b1);
      end
      for (int i = 0; i < 16; i++) wdata[i] = $urandom;
      run_cmd(32'h300, 4, 1'b1, 2, 1'b0);

      @(negedge clk);
      cmd_addr8 = 8'hFC; cmd_len8 = 16'd2; cmd_valid8 = 1'b1;
      @(negedge clk);
      cmd_valid8 = 1'b0;
      d8 = 0;
      for (int c = 0; c < 50; c++) begin
         if (done8) begin
            d8 = 1;
            break;
         end
         @(negedge clk);
      end
      check("wrap_done", 64'(d8), 64'(1));
      check("wrap_beats", 64'(adr8_log.size()), 64'(2));
      if (adr8_log.size() >= 2) begin
         check("wrap_adr0", 64'(adr8_log[0]), 64'(8'hFC));
         check("wrap_adr1", 64'(adr8_log[1]), 64'(8'h00));
      end

      // Reset in the middle of a write burst.
      a0 = ack_cnt;
      @(negedge clk);
      cmd_addr = 32'h140; cmd_len = 16'd4; cmd_we = 1'b1; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 0; c < 200 && ack_cnt - a0 < 2; c++) begin
         s_wr_valid = 1'b1;
         s_wr_data  = 32'hC0 + 32'(c);
         @(negedge clk);
      end
      check("mid_acks", 64'(ack_cnt - a0), 64'(2));
      check("mid_cyc", 64'(m_cyc_o), 64'(1));
      rst = 1'b1;
      s_wr_valid = 1'b0;
      @(negedge clk);
      check("mrst_cyc", 64'(m_cyc_o), 64'(0));
      check("mrst_ready", 64'(cmd_ready), 64'(1));
      check("mrst_busy", 64'(busy), 64'(0));
      check("mrst_adr", 64'(m_adr_o), 64'(0));
      check("mrst_dat", 64'(m_dat_o), 64'(0));
      check("mrst_rdata", 64'(m_rd_data), 64'(0));
      rst = 1'b0;
      a0 = ack_cnt;
      c0 = cyc_cycles;
      repeat (8) @(negedge clk);
      check("mrst_quiet_ack", 64'(ack_cnt - a0), 64'(0));
      check("mrst_quiet_cyc", 64'(cyc_cycles - c0), 64'(0));
      check("mrst_idle", 64'(cmd_ready), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
